// File: rtl/mem_wb_sel_ctrl_if.sv
// EX/MEM decode inputs and MEM/WB mux select outputs of the writeback select controller.
// The master drives the pipeline side and the slave is the controller.
interface mem_wb_sel_ctrl_if;
    logic       stall_in;
    logic [2:0] op_class;
    logic [3:0] dest_top_addr;
    logic [3:0] dest_bot_addr;
    logic       wr_top;
    logic       wr_bot;
    logic [3:0] src_top_addr;
    logic [3:0] src_bot_addr;
    logic [3:0] sel_signals_top;
    logic [6:0] sel_signals_bot;
    logic       mem_wb_we;
    logic       mem_rd_en;
    logic       stall_req;
    logic [7:0] stall_count;

    modport master (
        output stall_in, op_class, dest_top_addr, dest_bot_addr, wr_top, wr_bot,
               src_top_addr, src_bot_addr,
        input  sel_signals_top, sel_signals_bot, mem_wb_we, mem_rd_en, stall_req, stall_count
    );

    modport slave (
        input  stall_in, op_class, dest_top_addr, dest_bot_addr, wr_top, wr_bot,
               src_top_addr, src_bot_addr,
        output sel_signals_top, sel_signals_bot, mem_wb_we, mem_rd_en, stall_req, stall_count
    );
endinterface

// File: rtl/mem_wb_sel_ctrl.sv
// MEM/WB writeback select controller: op decode, two-deep destination history for
// MOV forwarding, two-cycle load sequencing and the single top-lane hazard stall.
module mem_wb_sel_ctrl (
    input  logic               clock,
    input  logic               reset,
    mem_wb_sel_ctrl_if.slave   bus
);
    typedef enum logic {IDLE = 1'b0, LD_WAIT = 1'b1} state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] top;
        logic [3:0] bot;
        logic       wt;
        logic       wb;
    } hist_t;

    state_t     r_state;
    hist_t      r_h0;
    hist_t      r_h1;
    logic [7:0] r_stall_cnt;

    logic       w_h0_top_hit_b;
    logic       w_h0_bot_hit_b;
    logic       w_h1_top_hit_b;
    logic       w_h1_bot_hit_b;
    logic       w_h0_top_hit_t;
    logic       w_h0_bot_hit_t;
    logic       w_h1_top_hit_t;
    logic       w_h1_bot_hit_t;
    logic [3:0] w_sel_top;
    logic [6:0] w_sel_bot;
    logic       w_we;
    logic       w_rd;
    logic       w_stall;

    // Forwarding matches only count written fields of valid entries
    assign w_h0_top_hit_b = r_h0.valid & r_h0.wt & (r_h0.top == bus.src_bot_addr);
    assign w_h0_bot_hit_b = r_h0.valid & r_h0.wb & (r_h0.bot == bus.src_bot_addr);
    assign w_h1_top_hit_b = r_h1.valid & r_h1.wt & (r_h1.top == bus.src_bot_addr);
    assign w_h1_bot_hit_b = r_h1.valid & r_h1.wb & (r_h1.bot == bus.src_bot_addr);
    assign w_h0_top_hit_t = r_h0.valid & r_h0.wt & (r_h0.top == bus.src_top_addr);
    assign w_h0_bot_hit_t = r_h0.valid & r_h0.wb & (r_h0.bot == bus.src_top_addr);
    assign w_h1_top_hit_t = r_h1.valid & r_h1.wt & (r_h1.top == bus.src_top_addr);
    assign w_h1_bot_hit_t = r_h1.valid & r_h1.wb & (r_h1.bot == bus.src_top_addr);

    // Select, write-enable, read strobe and stall decode
    always_comb begin
        w_sel_top = 4'b0000;
        w_sel_bot = 7'b0000000;
        w_we      = 1'b0;
        w_rd      = 1'b0;
        w_stall   = 1'b0;
        if (reset || bus.stall_in) begin
            w_we = 1'b0;
        end else if (r_state == LD_WAIT) begin
            w_sel_top = 4'b0010;
            w_sel_bot = 7'b0000100;
            w_we      = 1'b1;
        end else begin
            case (bus.op_class)
                3'd1: begin
                    w_sel_top = 4'b0001;
                    w_sel_bot = 7'b0000010;
                    w_we      = 1'b1;
                end
                3'd2: begin
                    w_sel_bot = 7'b0000001;
                    w_we      = 1'b1;
                end
                3'd3: begin
                    w_rd    = 1'b1;
                    w_stall = 1'b1;
                end
                3'd4: begin
                    // The top lane has no MEM/WB input, so an H0 source must wait a cycle
                    if (w_h0_top_hit_t || w_h0_bot_hit_t) begin
                        w_stall = 1'b1;
                    end else begin
                        w_we = 1'b1;
                        if (w_h1_top_hit_t) begin
                            w_sel_top = 4'b0100;
                        end else if (w_h1_bot_hit_t) begin
                            w_sel_top = 4'b1000;
                        end else begin
                            w_sel_top = 4'b0001;
                        end
                        if (w_h0_top_hit_b) begin
                            w_sel_bot = 7'b0001000;
                        end else if (w_h0_bot_hit_b) begin
                            w_sel_bot = 7'b0010000;
                        end else if (w_h1_top_hit_b) begin
                            w_sel_bot = 7'b0100000;
                        end else if (w_h1_bot_hit_b) begin
                            w_sel_bot = 7'b1000000;
                        end else begin
                            w_sel_bot = 7'b0000010;
                        end
                    end
                end
                default: begin
                    w_we = 1'b0;
                end
            endcase
        end
    end

    // FSM, history shift and saturating stall counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_h0        <= '0;
            r_h1        <= '0;
            r_stall_cnt <= 8'h00;
        end else if (!bus.stall_in) begin
            r_h1 <= r_h0;
            if (w_we) begin
                r_h0 <= '{valid: 1'b1, top: bus.dest_top_addr, bot: bus.dest_bot_addr,
                          wt: bus.wr_top, wb: bus.wr_bot};
            end else begin
                r_h0 <= '0;
            end
            case (r_state)
                IDLE:    r_state <= w_rd ? LD_WAIT : IDLE;
                LD_WAIT: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_stall && (r_stall_cnt != 8'hFF)) begin
                r_stall_cnt <= r_stall_cnt + 8'h01;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end else begin
            r_state <= r_state;
        end
    end

    assign bus.sel_signals_top = w_sel_top;
    assign bus.sel_signals_bot = w_sel_bot;
    assign bus.mem_wb_we       = w_we;
    assign bus.mem_rd_en       = w_rd;
    assign bus.stall_req       = w_stall;
    assign bus.stall_count     = reset ? 8'h00 : r_stall_cnt;
endmodule

// File: tb/tb_mem_wb_sel_ctrl.sv
// Directed scoreboard bench for mem_wb_sel_ctrl: expected outputs are queued as each
// cycle is driven and checked mid-cycle once the combinational outputs have settled.
module tb_mem_wb_sel_ctrl;
    logic clock;
    logic reset;
    mem_wb_sel_ctrl_if bif ();

    mem_wb_sel_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    typedef struct {
        logic [3:0] top;
        logic [6:0] bot;
        logic       we;
        logic       rd;
        logic       stl;
        logic [7:0] cnt;
        string      tag;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_mis = 0;
    logic [7:0] exp_cnt = 8'h00;

    always #5 clock = ~clock;

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic rst, input logic sin, input logic [2:0] op,
                        input logic [3:0] dt, input logic [3:0] db, input logic wt, input logic wb,
                        input logic [3:0] st, input logic [3:0] sb,
                        input logic [3:0] e_top, input logic [6:0] e_bot,
                        input logic e_we, input logic e_rd, input logic e_stl, input string tag);
        exp_t e;
        reset             = rst;
        bif.stall_in      = sin;
        bif.op_class      = op;
        bif.dest_top_addr = dt;
        bif.dest_bot_addr = db;
        bif.wr_top        = wt;
        bif.wr_bot        = wb;
        bif.src_top_addr  = st;
        bif.src_bot_addr  = sb;
        exp_q.push_back('{top: e_top, bot: e_bot, we: e_we, rd: e_rd, stl: e_stl,
                          cnt: (rst ? 8'h00 : exp_cnt), tag: tag});
        @(negedge clock);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $error("FAIL %s observed=empty expected=queued", tag);
        end else begin
            e = exp_q.pop_front();
            cmp({e.tag, ".top"}, {4'h0, bif.sel_signals_top}, {4'h0, e.top});
            cmp({e.tag, ".bot"}, {1'b0, bif.sel_signals_bot}, {1'b0, e.bot});
            cmp({e.tag, ".we"},  {7'h00, bif.mem_wb_we}, {7'h00, e.we});
            cmp({e.tag, ".rd"},  {7'h00, bif.mem_rd_en}, {7'h00, e.rd});
            cmp({e.tag, ".stall"}, {7'h00, bif.stall_req}, {7'h00, e.stl});
            cmp({e.tag, ".cnt"}, bif.stall_count, e.cnt);
        end
        @(posedge clock);
        #1;
        if (rst) begin
            exp_cnt = 8'h00;
        end else if (e_stl && !sin && exp_cnt != 8'hFF) begin
            exp_cnt = exp_cnt + 8'h01;
        end
    endtask

    initial begin
        clock = 1'b0;
        reset = 1'b1;
        bif.stall_in = 1'b0; bif.op_class = 3'd0;
        bif.dest_top_addr = 4'd0; bif.dest_bot_addr = 4'd0;
        bif.wr_top = 1'b0; bif.wr_bot = 1'b0;
        bif.src_top_addr = 4'd0; bif.src_bot_addr = 4'd0;
        @(posedge clock);
        #1;
        // rst sin op  dt  db  wt wb st  sb   top      bot         we rd stl
        step(1'b1, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0000, 7'b0000000, 1'b0, 1'b0, 1'b0, "rst0");
        step(1'b1, 1'b0, 3'd3, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0000, 7'b0000000, 1'b0, 1'b0, 1'b0, "rst1");
        // Reset landing in LD_WAIT
        step(1'b0, 1'b0, 3'd3, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 4'b0000, 7'b0000000, 1'b0, 1'b1, 1'b1, "ld_a");
        step(1'b1, 1'b0, 3'd3, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 4'b0000, 7'b0000000, 1'b0, 1'b0, 1'b0, "rst_ldw");
        step(1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0000, 7'b0000000, 1'b0, 1'b0, 1'b0, "post_rst");
        // MOV bottom from H0 bottom
        step(1'b0, 1'b0, 3'd1, 4'd3, 4'd4, 1'b1, 1'b1, 4'd0, 4'd0, 4'b0001, 7'b0000010, 1'b1, 1'b0, 1'b0, "alu34");
        step(1'b0, 1'b0, 3'd4, 4'd10, 4'd0, 1'b1, 1'b0, 4'd9, 4'd4, 4'b0001, 7'b0010000, 1'b1, 1'b0, 1'b0, "mov_b");
        // MOV top hazard then retry from H1
        step(1'b0, 1'b0, 3'd1, 4'd2, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 4'b0001, 7'b0000010, 1'b1, 1'b0, 1'b0, "alu2");
        step(1'b0, 1'b0, 3'd4, 4'd11, 4'd0, 1'b1, 1'b0, 4'd2, 4'd15, 4'b0000, 7'b0000000, 1'b0, 1'b0, 1'b1, "mov_hz");
        step(1'b0, 1'b0, 3'd4, 4'd11, 4'd0, 1'b1, 1'b0, 4'd2, 4'd15, 4'b0100, 7'b0000010, 1'b1, 1'b0, 1'b0, "mov_rt");
        step(1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0000, 7'b0000000, 1'b0, 1'b0, 1'b0, "cnt1");
        // Two-cycle load; H0 then holds its destination
        step(1'b0, 1'b0, 3'd3, 4'd6, 4'd7, 1'b1, 1'b1, 4'd0, 4'd0, 4'b0000, 7'b0000000, 1'b0, 1'b1, 1'b1, "ld_b");
        step(1'b0, 1'b0, 3'd3, 4'd6, 4'd7, 1'b1, 1'b1, 4'd0, 4'd0, 4'b0010, 7'b0000100, 1'b1, 1'b0, 1'b0, "ld_b2");
        step(1'b0, 1'b0, 3'd4, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1, 4'd7, 4'b0001, 7'b0010000, 1'b1, 1'b0, 1'b0, "mov_ld");
        // Bottom-lane priority: H0 top beats H1 bottom, and H0 top beats H0 bottom
        step(1'b0, 1'b0, 3'd1, 4'd0, 4'd5, 1'b0, 1'b1, 4'd0, 4'd0, 4'b0001, 7'b0000010, 1'b1, 1'b0, 1'b0, "alu_p1");
        step(1'b0, 1'b0, 3'd1, 4'd5, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 4'b0001, 7'b0000010, 1'b1, 1'b0, 1'b0, "alu_p2");
        step(1'b0, 1'b0, 3'd4, 4'd11, 4'd0, 1'b1, 1'b0, 4'd12, 4'd5, 4'b0001, 7'b0001000, 1'b1, 1'b0, 1'b0, "mov_pr");
        step(1'b0, 1'b0, 3'd1, 4'd8, 4'd8, 1'b1, 1'b1, 4'd0, 4'd0, 4'b0001, 7'b0000010, 1'b1, 1'b0, 1'b0, "alu_same");
        step(1'b0, 1'b0, 3'd4, 4'd11, 4'd0, 1'b1, 1'b0, 4'd3, 4'd8, 4'b0001, 7'b0001000, 1'b1, 1'b0, 1'b0, "mov_same");
        // Both lanes from H1 bottom across a bubble
        step(1'b0, 1'b0, 3'd1, 4'd0, 4'd9, 1'b0, 1'b1, 4'd0, 4'd0, 4'b0001, 7'b0000010, 1'b1, 1'b0, 1'b0, "alu_9");
        step(1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0000, 7'b0000000, 1'b0, 1'b0, 1'b0, "nop");
        step(1'b0, 1'b0, 3'd4, 4'd0, 4'd0, 1'b0, 1'b0, 4'd9, 4'd9, 4'b1000, 7'b1000000, 1'b1, 1'b0, 1'b0, "mov_t1b");
        step(1'b0, 1'b0, 3'd2, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 4'b0000, 7'b0000001, 1'b1, 1'b0, 1'b0, "sfr");
        step(1'b0, 1'b0, 3'd6, 4'd1, 4'd1, 1'b1, 1'b1, 4'd0, 4'd0, 4'b0000, 7'b0000000, 1'b0, 1'b0, 1'b0, "op6");
        // Downstream freeze while in LD_WAIT
        step(1'b0, 1'b0, 3'd3, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0000, 7'b0000000, 1'b0, 1'b1, 1'b1, "ld_c");
        step(1'b0, 1'b1, 3'd3, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0000, 7'b0000000, 1'b0, 1'b0, 1'b0, "ldw_frz1");
        step(1'b0, 1'b1, 3'd3, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0000, 7'b0000000, 1'b0, 1'b0, 1'b0, "ldw_frz2");
        step(1'b0, 1'b0, 3'd3, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0010, 7'b0000100, 1'b1, 1'b0, 1'b0, "ldw_go");
        // Back-to-back loads drive the stall counter into saturation
        for (int i = 0; i < 520; i++) begin
            if ((i % 2) == 0) begin
                step(1'b0, 1'b0, 3'd3, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0000, 7'b0000000, 1'b0, 1'b1, 1'b1, "sat_ld");
            end else begin
                step(1'b0, 1'b0, 3'd3, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0010, 7'b0000100, 1'b1, 1'b0, 1'b0, "sat_ldw");
            end
        end
        // History and count hold through a three-cycle freeze
        step(1'b0, 1'b0, 3'd1, 4'd7, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 4'b0001, 7'b0000010, 1'b1, 1'b0, 1'b0, "alu7");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 3'd1, 4'd3, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 4'b0000, 7'b0000000, 1'b0, 1'b0, 1'b0, "frz");
        end
        step(1'b0, 1'b0, 3'd4, 4'd0, 4'd0, 1'b0, 1'b0, 4'd13, 4'd7, 4'b0001, 7'b0001000, 1'b1, 1'b0, 1'b0, "mov_frz");
        step(1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0000, 7'b0000000, 1'b0, 1'b0, 1'b0, "final_cnt");
        n_cmp++;
        assert (exp_cnt === 8'hFF) else begin
            n_mis++;
            $error("FAIL sat_model observed=%h expected=ff", exp_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
